lcd_cmd_sched: RTL and testbench
================================

// Module: lcd_cmd_sched
// PURPOSE
//  Host-side command scheduler for the LCD image-processing engine. Buffers host commands in a FIFO.
//  Issues each command to the engine as a one-cycle pulse, only while the engine is not busy.
//  Tracks the final WRITE command through to eng_done. Sits between the testbench/host and the engine.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of 2, >=2
//  GUARD  2  cycles held after each issue before eng_busy is trusted (engine raises busy late)
//  CW     4  command width
// PORTS
//  clk           in   1           clock
//  reset         in   1           asynchronous, active-high
//  host_cmd      in   CW          command code (0 WRITE, 1-4 SHIFT U/D/L/R, 5 MAX, 6 MIN, 7 AVG, 8 CCW, 9 CW, 10 MX, 11 MY)
//  host_valid    in   1           host offers host_cmd
//  host_ready    out  1           scheduler accepts; transfer on valid&&ready at posedge
//  eng_cmd       out  CW          command to engine; registered
//  eng_cmd_valid out  1           one-cycle issue pulse
//  eng_busy      in   1           engine busy (high during image load and multi-cycle ops)
//  eng_done      in   1           engine finished output of the image
//  fifo_level    out  clog2(DEPTH)+1  entries held
//  sched_idle    out  1           FIFO empty and state IDLE
//  sched_done    out  1           sticky; eng_done seen after WRITE issued
//  err_illegal   out  1           sticky; a code 12-15 reached the FIFO head
// BEHAVIOUR
//  Reset: all outputs 0 except sched_idle=1; FIFO empty; state IDLE; write_seen=0.
//  host_ready = !full && !write_seen && state!=DONE. Full/write_seen are registered; no combinational path from eng_*.
//  Accepting cmd 0 sets write_seen; no further commands are accepted until reset.
//  FSM:
//   IDLE  -> ISSUE when FIFO non-empty && !eng_busy.
//   ISSUE: eng_cmd_valid=1, eng_cmd=head, pop.
//          Head 0 -> DRAIN; head 12-15 -> no pulse, pop, set err_illegal, -> IDLE; else -> GUARD.
//   GUARD: count GUARD cycles, pulse low -> WAIT.
//   WAIT  -> IDLE when !eng_busy.
//   DRAIN -> DONE on eng_done.
//   DONE: sched_done=1; stays until reset.
//  Min latency: accepted at edge N -> eng_cmd_valid high in cycle N+2. There is no bypass path.
//  Push and pop in the same cycle are both honoured; fifo_level is unchanged.
//  eng_busy high at reset (image load) stalls IDLE; the FIFO still fills to DEPTH.
//  Pointers wrap modulo DEPTH; an extra wrap bit separates full from empty.
//  eng_done outside DRAIN is ignored.
//  Reset mid-operation: everything returns to reset values immediately; queued commands are lost.
// CONFIGURATION
//  LCD_SCHED_STATS_EN defined: adds output issue_count[15:0].
//   Increments on every eng_cmd_valid pulse; saturates at 16'hFFFF; cleared by reset.
//  LCD_SCHED_STATS_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package lcd_pkg: CW, command code constants/enum (WRITE..MIRROR_Y), sched state enum
//   (IDLE, ISSUE, GUARD, WAIT, DRAIN, DONE), is_legal_cmd() function.
//  Sub-module lcd_cmd_fifo: synchronous FIFO with DEPTH, level, full/empty outputs.
//   Top module holds the FSM, guard counter and sticky flags.
// TESTING
//  1. eng_busy=1 for 20 cycles; push 5,1,7,0 -> no issue while busy.
//     After busy falls, issues in order 5,1,7,0, each >=GUARD+1 cycles apart.
//  2. Push cmd 3 with FIFO empty, eng_busy=0, accept at edge N -> eng_cmd_valid=1, eng_cmd=3 in cycle N+2.
//  3. Keep eng_busy=1, push 6 commands with DEPTH=4 -> host_ready=0 after 4th accept, fifo_level=4.
//     Drop busy -> pops, 5th and 6th accepted.
//  4. Push 9 then 0; attempt push 2 -> 2 not accepted.
//     eng_done pulse while in DRAIN -> sched_done=1, sticky.
//  5. Push 13 then 4 -> err_illegal=1, no pulse for 13, 4 issued normally.
//  6. Assert reset mid-GUARD with 3 queued -> fifo_level=0, eng_cmd_valid=0, sched_idle=1, flags cleared.
//     With LCD_SCHED_STATS_EN, issue_count returns to 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types for the LCD command scheduler: command codes, scheduler states, legality check.
package lcd_pkg;

  localparam int CW = 4;

  typedef enum logic [CW-1:0] {
    CMD_WRITE    = 4'd0,
    CMD_SHIFT_U  = 4'd1,
    CMD_SHIFT_D  = 4'd2,
    CMD_SHIFT_L  = 4'd3,
    CMD_SHIFT_R  = 4'd4,
    CMD_MAX      = 4'd5,
    CMD_MIN      = 4'd6,
    CMD_AVG      = 4'd7,
    CMD_ROT_CCW  = 4'd8,
    CMD_ROT_CW   = 4'd9,
    CMD_MIRROR_X = 4'd10,
    CMD_MIRROR_Y = 4'd11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GUARD,
    ST_WAIT,
    ST_DRAIN,
    ST_DONE
  } sched_state_e;

  function automatic logic is_legal_cmd(input logic [CW-1:0] c);
    return c <= CMD_MIRROR_Y;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous FIFO with wrap-bit pointers; level/full/empty derived from the pointer difference.
module lcd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say they are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/lcd_cmd_sched.sv
// Host command scheduler: queues commands, issues one-cycle pulses to the engine when not busy.
// Optional issue counter port issue_count when LCD_SCHED_STATS_EN is defined.
module lcd_cmd_sched #(
  parameter int DEPTH = 4,
  parameter int GUARD = 2,
  parameter int CW    = lcd_pkg::CW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CW-1:0]          host_cmd,
  input  logic                   host_valid,
  output logic                   host_ready,
  output logic [CW-1:0]          eng_cmd,
  output logic                   eng_cmd_valid,
  input  logic                   eng_busy,
  input  logic                   eng_done,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   sched_idle,
  output logic                   sched_done,
`ifdef LCD_SCHED_STATS_EN
  output logic [15:0]            issue_count,
`endif
  output logic                   err_illegal
);

  import lcd_pkg::*;

  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

  sched_state_e  state;
  logic [GW-1:0] guard_cnt;
  logic          write_seen;
  logic          push;
  logic          pop;
  logic [CW-1:0] head;
  logic          full;
  logic          empty;

  lcd_cmd_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (host_cmd),
    .pop   (pop),
    .dout  (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  // Ready depends only on registered state so the engine side never reaches the host handshake.
  assign host_ready = !full && !write_seen && (state != ST_DONE);
  assign push       = host_valid && host_ready;
  assign pop        = (state == ST_ISSUE);
  assign sched_idle = empty && (state == ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      guard_cnt     <= '0;
      eng_cmd       <= '0;
      eng_cmd_valid <= 1'b0;
      sched_done    <= 1'b0;
      err_illegal   <= 1'b0;
      write_seen    <= 1'b0;
    end else begin
      eng_cmd_valid <= 1'b0;
      if (push && host_cmd == CMD_WRITE) write_seen <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!empty && !eng_busy) state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (!is_legal_cmd(head)) begin
            err_illegal <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            eng_cmd_valid <= 1'b1;
            eng_cmd       <= head;
            guard_cnt     <= '0;
            if (head == CMD_WRITE) state <= ST_DRAIN;
            else                   state <= ST_GUARD;
          end
        end
        ST_GUARD: begin
          // Engine raises busy a few cycles late, so ignore it until the guard expires.
          if (guard_cnt == GW'(GUARD - 1)) state <= ST_WAIT;
          else                             guard_cnt <= guard_cnt + 1'b1;
        end
        ST_WAIT: begin
          if (!eng_busy) state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (eng_done) begin
            state      <= ST_DONE;
            sched_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LCD_SCHED_STATS_EN
  // Counts at the same edge the pulse is raised, so it tracks eng_cmd_valid exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_count <= '0;
    end else if (state == ST_ISSUE && is_legal_cmd(head) && issue_count != 16'hFFFF) begin
      issue_count <= issue_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Directed bench for lcd_cmd_sched: latency table plus multi-cycle sequences.
module tb_lcd_cmd_sched;

  logic       clk;
  logic       reset;
  logic [3:0] host_cmd;
  logic       host_valid;
  logic       host_ready;
  logic [3:0] eng_cmd;
  logic       eng_cmd_valid;
  logic       eng_busy;
  logic       eng_done;
  logic [2:0] fifo_level;
  logic       sched_idle;
  logic       sched_done;
  logic       err_illegal;
`ifdef LCD_SCHED_STATS_EN
  logic [15:0] issue_count;
`endif

  lcd_cmd_sched #(.DEPTH(4), .GUARD(2), .CW(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .host_cmd      (host_cmd),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .eng_cmd       (eng_cmd),
    .eng_cmd_valid (eng_cmd_valid),
    .eng_busy      (eng_busy),
    .eng_done      (eng_done),
    .fifo_level    (fifo_level),
    .sched_idle    (sched_idle),
    .sched_done    (sched_done),
`ifdef LCD_SCHED_STATS_EN
    .issue_count   (issue_count),
`endif
    .err_illegal   (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [3:0] iss_q[$];
  int         iss_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (eng_cmd_valid === 1'b1) begin
      iss_q.push_back(eng_cmd);
      iss_cyc.push_back(cyc);
    end
  end

  typedef struct {
    logic [3:0] cmd;
    logic       exp_pulse;
    logic       exp_err;
    logic       exp_ready;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic busy);
    reset      = 1'b1;
    eng_busy   = busy;
    eng_done   = 1'b0;
    host_valid = 1'b0;
    host_cmd   = 4'd0;
    step();
    step();
    reset = 1'b0;
    iss_q.delete();
    iss_cyc.delete();
  endtask

  task automatic push(input logic [3:0] c, output bit acc);
    host_cmd   = c;
    host_valid = 1'b1;
    acc        = host_ready;
    step();
    host_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [3:0] c, input int budget, output bit acc);
    acc = 1'b0;
    for (int i = 0; i < budget && !acc; i++) push(c, acc);
  endtask

  task automatic wait_issued(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (iss_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check(name, (iss_q.size() >= n), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit acc;
    int k;

    vecs[0] = '{cmd: 4'd3,  exp_pulse: 1'b1, exp_err: 1'b0, exp_ready: 1'b1};
    vecs[1] = '{cmd: 4'd1,  exp_pulse: 1'b1, exp_err: 1'b0, exp_ready: 1'b1};
    vecs[2] = '{cmd: 4'd11, exp_pulse: 1'b1, exp_err: 1'b0, exp_ready: 1'b1};
    vecs[3] = '{cmd: 4'd13, exp_pulse: 1'b0, exp_err: 1'b1, exp_ready: 1'b1};
    vecs[4] = '{cmd: 4'd15, exp_pulse: 1'b0, exp_err: 1'b1, exp_ready: 1'b1};
    vecs[5] = '{cmd: 4'd0,  exp_pulse: 1'b1, exp_err: 1'b0, exp_ready: 1'b0};

    reset = 1'b1; eng_busy = 1'b0; eng_done = 1'b0; host_valid = 1'b0; host_cmd = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst eng_cmd_valid", eng_cmd_valid, 0);
    check("rst eng_cmd", eng_cmd, 0);
    check("rst fifo_level", fifo_level, 0);
    check("rst sched_idle", sched_idle, 1);
    check("rst sched_done", sched_done, 0);
    check("rst err_illegal", err_illegal, 0);
    reset = 1'b0;
    check("rst host_ready", host_ready, 1);

    // Latency table: accept at edge N, pulse visible after edge N+2.
    for (int v = 0; v < 6; v++) begin
      do_reset(1'b0);
      push(vecs[v].cmd, acc);
      check($sformatf("lat%0d accept", v), acc, 1);
      step();
      check($sformatf("lat%0d early pulse", v), eng_cmd_valid, 0);
      step();
      check($sformatf("lat%0d pulse", v), eng_cmd_valid, vecs[v].exp_pulse);
      check($sformatf("lat%0d eng_cmd", v), eng_cmd, vecs[v].exp_pulse ? vecs[v].cmd : 4'd0);
      step();
      check($sformatf("lat%0d pulse width", v), eng_cmd_valid, 0);
      check($sformatf("lat%0d err", v), err_illegal, vecs[v].exp_err);
      check($sformatf("lat%0d ready", v), host_ready, vecs[v].exp_ready);
    end

    // Busy at reset: nothing issues; then strict order with guard spacing.
    do_reset(1'b1);
    push(4'd5, acc); push(4'd1, acc); push(4'd7, acc); push(4'd0, acc);
    repeat (16) step();
    check("busy no issue", iss_q.size(), 0);
    check("busy level", fifo_level, 4);
    eng_busy = 1'b0;
    wait_issued(4, 100, "order timeout");
    check("order 0", iss_q[0], 5);
    check("order 1", iss_q[1], 1);
    check("order 2", iss_q[2], 7);
    check("order 3", iss_q[3], 0);
    for (int i = 1; i < 4; i++)
      check($sformatf("spacing %0d", i), (iss_cyc[i] - iss_cyc[i-1]) >= 3, 1);

    // Full FIFO backpressure.
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      push(4'(i + 1), acc);
      check($sformatf("fill accept %0d", i), acc, 1);
    end
    check("full ready", host_ready, 0);
    check("full level", fifo_level, 4);
    push(4'd5, acc);
    check("full reject", acc, 0);
    eng_busy = 1'b0;
    push_wait(4'd5, 40, acc);
    check("5th accept", acc, 1);
    push_wait(4'd6, 40, acc);
    check("6th accept", acc, 1);
    wait_issued(6, 200, "full timeout");
    check("full issue 4", iss_q[4], 5);
    check("full issue 5", iss_q[5], 6);

    // WRITE closes the door; eng_done ignored outside DRAIN.
    do_reset(1'b0);
    push(4'd9, acc);
    push(4'd0, acc);
    push(4'd2, acc);
    check("after write reject", acc, 0);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check("done ignored", sched_done, 0);
    wait_issued(2, 50, "write timeout");
    check("write issue 0", iss_q[0], 9);
    check("write issue 1", iss_q[1], 0);
    step(); step();
    check("drain not done", sched_done, 0);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check("done set", sched_done, 1);
    repeat (5) step();
    check("done sticky", sched_done, 1);
    check("done ready", host_ready, 0);
    check("done issues", iss_q.size(), 2);

    // Illegal head skipped.
    do_reset(1'b0);
    push(4'd13, acc);
    push(4'd4, acc);
    wait_issued(1, 50, "illegal timeout");
    check("illegal skip", iss_q[0], 4);
    check("illegal err", err_illegal, 1);
    repeat (8) step();
    check("illegal count", iss_q.size(), 1);

    // Reset mid-GUARD with three queued; also simultaneous push/pop.
    do_reset(1'b0);
    push(4'd13, acc);
    check("mid lvl1", fifo_level, 1);
    push(4'd1, acc);
    check("mid lvl2", fifo_level, 2);
    eng_busy = 1'b1;
    push(4'd2, acc);
    check("push+pop level", fifo_level, 2);
    check("mid err", err_illegal, 1);
    push(4'd3, acc);
    push(4'd4, acc);
    check("mid lvl4", fifo_level, 4);
    eng_busy = 1'b0;
    k = 0;
    while (eng_cmd_valid !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check("mid pulse seen", eng_cmd_valid, 1);
    check("mid eng_cmd", eng_cmd, 1);
    check("mid queued", fifo_level, 3);
`ifdef LCD_SCHED_STATS_EN
    check("stats count", issue_count, 1);
`endif
    reset = 1'b1;
    #1;
    check("mid rst level", fifo_level, 0);
    check("mid rst valid", eng_cmd_valid, 0);
    check("mid rst idle", sched_idle, 1);
    check("mid rst err", err_illegal, 0);
    check("mid rst done", sched_done, 0);
`ifdef LCD_SCHED_STATS_EN
    check("stats rst", issue_count, 0);
`endif
    step();
    reset = 1'b0;
    check("mid rst ready", host_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
